// File: rtl/order_generator_pkg.sv
// Shared FSM encoding, LFSR constants and small arithmetic helpers for the
// synthetic order generator.
package order_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_GEN   = 2'd2,
        ST_OFFER = 2'd3
    } state_e;

    localparam logic [15:0] SEED_DEFAULT = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;

    // One step of the right-shifting Galois LFSR.
    function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
        logic [15:0] mask;
        if (cur[0]) begin
            mask = LFSR_TAPS;
        end else begin
            mask = 16'h0000;
        end
        return (cur >> 1) ^ mask;
    endfunction

    // Saturate a signed intermediate price into [lo, hi].
    function automatic logic [7:0] clamp_price(input logic signed [10:0] val,
                                               input logic [7:0]         lo,
                                               input logic [7:0]         hi);
        logic [7:0] res;
        if (val < $signed({3'b000, lo})) begin
            res = lo;
        end else if (val > $signed({3'b000, hi})) begin
            res = hi;
        end else begin
            res = val[7:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/order_generator_if.sv
// Order handshake bundle between the generator (master) and the matching side.
interface order_generator_if;

    logic       order_valid;
    logic       order_ready;
    logic       match_flag;
    logic [7:0] buy_price;
    logic [7:0] sell_price;
    logic [7:0] order_id;

    modport master (
        output order_valid,
        output buy_price,
        output sell_price,
        output order_id,
        input  order_ready,
        input  match_flag
    );

    modport slave (
        input  order_valid,
        input  buy_price,
        input  sell_price,
        input  order_id,
        output order_ready,
        output match_flag
    );

endinterface

// File: rtl/order_generator_lfsr16.sv
// 16-bit Galois LFSR with a synchronous load port and a single-step advance.
module lfsr16
    import order_pkg::*;
#(
    parameter logic [15:0] RESET_VAL = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        advance,
    output logic [15:0] state
);

    logic [15:0] state_q;
    logic [15:0] state_d;

    // Load wins over advance; the owner only loads while idle, so they never meet.
    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = load_val;
        end else if (advance) begin
            state_d = lfsr_step(state_q);
        end else begin
            state_d = state_q;
        end
    end

    // LFSR register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RESET_VAL;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/order_generator.sv
// Synthetic order source: paces orders by an interval, random-walks a mid-price
// from an LFSR and offers buy/sell pairs over a valid/ready handshake.
module order_generator #(
    parameter logic [15:0] SEED_DEFAULT = order_pkg::SEED_DEFAULT,
    parameter logic [7:0]  MID_INIT     = 8'd128,
    parameter logic [7:0]  PRICE_LO     = 8'd8,
    parameter logic [7:0]  PRICE_HI     = 8'd247
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     seed_load,
    input  logic [15:0]              seed,
    input  logic [7:0]               interval,
    order_generator_if.master        bus,
    output logic [15:0]              match_count
);

    import order_pkg::*;

    state_e             state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [7:0]         mid_q, mid_d;
    logic [7:0]         buy_q, buy_d;
    logic [7:0]         sell_q, sell_d;
    logic [7:0]         id_q, id_d;
    logic [15:0]        mcnt_q, mcnt_d;
    logic               valid_q, valid_d;

    logic               hs_s;
    logic               lfsr_load_s;
    logic               lfsr_adv_s;
    logic [15:0]        lfsr_seed_s;
    logic [15:0]        lfsr_state;
    logic [15:0]        lfsr_next_s;
    logic signed [10:0] mid_raw_s;
    logic [7:0]         mid_new_s;
    logic               unused_lfsr_s;

    assign hs_s        = valid_q & bus.order_ready;
    assign lfsr_seed_s = (seed == 16'h0000) ? SEED_DEFAULT : seed;

    lfsr16 #(
        .RESET_VAL (SEED_DEFAULT)
    ) u_lfsr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (lfsr_load_s),
        .load_val (lfsr_seed_s),
        .advance  (lfsr_adv_s),
        .state    (lfsr_state)
    );

    // Prices are derived from the value the LFSR takes during GEN; only the low bits matter.
    assign lfsr_next_s   = lfsr_step(lfsr_state);
    assign unused_lfsr_s = ^lfsr_next_s[15:9];

    // Sequencing FSM: IDLE -> WAIT (interval+1 cycles) -> GEN -> OFFER until accepted.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lfsr_load_s = 1'b0;
        lfsr_adv_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                lfsr_load_s = seed_load;
                if (enable) begin
                    state_d = ST_WAIT;
                    cnt_d   = interval;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == 8'd0) begin
                    state_d = ST_GEN;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_GEN: begin
                state_d    = ST_OFFER;
                lfsr_adv_s = 1'b1;
            end
            ST_OFFER: begin
                // Once offered, an order leaves only through a handshake.
                if (hs_s) begin
                    if (enable) begin
                        state_d = ST_WAIT;
                        cnt_d   = interval;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_OFFER;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 8'd0;
            end
        endcase
        valid_d = (state_d == ST_OFFER);
    end

    // Mid-price random walk and quote generation, committed only in GEN.
    always_comb begin
        mid_raw_s = $signed({3'b000, mid_q}) + $signed({8'b0000_0000, lfsr_next_s[2:0]}) - 11'sd4;
        mid_new_s = clamp_price(mid_raw_s, PRICE_LO, PRICE_HI);
        mid_d     = mid_q;
        buy_d     = buy_q;
        sell_d    = sell_q;
        if (state_q == ST_GEN) begin
            mid_d  = mid_new_s;
            buy_d  = mid_new_s + {5'b00000, lfsr_next_s[5:3]} - 8'd4;
            sell_d = mid_new_s + {5'b00000, lfsr_next_s[8:6]} - 8'd3;
        end else begin
            mid_d  = mid_q;
            buy_d  = buy_q;
            sell_d = sell_q;
        end
    end

    // Order id wraps naturally; the match counter sticks at its maximum.
    always_comb begin
        id_d   = id_q;
        mcnt_d = mcnt_q;
        if (hs_s) begin
            id_d = id_q + 8'd1;
            if (bus.match_flag && (mcnt_q != 16'hFFFF)) begin
                mcnt_d = mcnt_q + 16'd1;
            end else begin
                mcnt_d = mcnt_q;
            end
        end else begin
            id_d   = id_q;
            mcnt_d = mcnt_q;
        end
    end

    // All state with synchronous active-low reset; reset also cancels a pending handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            mid_q   <= MID_INIT;
            buy_q   <= MID_INIT;
            sell_q  <= MID_INIT;
            id_q    <= 8'd0;
            mcnt_q  <= 16'd0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mid_q   <= mid_d;
            buy_q   <= buy_d;
            sell_q  <= sell_d;
            id_q    <= id_d;
            mcnt_q  <= mcnt_d;
            valid_q <= valid_d;
        end
    end

    assign bus.order_valid = valid_q;
    assign bus.buy_price   = buy_q;
    assign bus.sell_price  = sell_q;
    assign bus.order_id    = id_q;
    assign match_count     = mcnt_q;

endmodule

// File: tb/tb_order_generator.sv
// Scoreboard bench for order_generator: stimulus pushes expected orders, a
// negedge monitor pops and compares them at every handshake.
module tb_order_generator;

    typedef struct packed {
        logic [7:0]  buy;
        logic [7:0]  sell;
        logic [7:0]  id;
        logic [15:0] mc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        seed_load;
    logic [15:0] seed;
    logic [7:0]  interval;
    logic [15:0] match_count;

    order_generator_if bus();
    assign bus.match_flag = (bus.buy_price >= bus.sell_price);

    order_generator #(
        .SEED_DEFAULT (16'hACE1),
        .MID_INIT     (8'd128),
        .PRICE_LO     (8'd8),
        .PRICE_HI     (8'd247)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .seed_load   (seed_load),
        .seed        (seed),
        .interval    (interval),
        .bus         (bus),
        .match_count (match_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t exp_q[$];
    int   hs_cyc[$];
    int   hs_count = 0;

    logic [15:0] m_lfsr;
    logic [7:0]  m_mid;
    logic [7:0]  m_id;
    logic [15:0] m_mc;
    exp_t        last_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model of one generated order.
    task automatic gen_order(output exp_t e);
        int          nm;
        logic [15:0] n;
        n      = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
        m_lfsr = n;
        nm     = int'(m_mid) + int'(n[2:0]) - 4;
        if (nm < 8) nm = 8;
        else if (nm > 247) nm = 247;
        m_mid  = nm[7:0];
        e.buy  = 8'(nm + int'(n[5:3]) - 4);
        e.sell = 8'(nm + int'(n[8:6]) - 3);
        e.id   = m_id;
        e.mc   = m_mc;
        m_id   = m_id + 8'd1;
        if (e.buy >= e.sell && m_mc != 16'hFFFF) m_mc = m_mc + 16'd1;
    endtask

    task automatic push_order();
        exp_t e;
        gen_order(e);
        exp_q.push_back(e);
        last_e = e;
    endtask

    task automatic model_reset();
        m_lfsr = 16'hACE1;
        m_mid  = 8'd128;
        m_id   = 8'd0;
        m_mc   = 16'd0;
    endtask

    // Wait (bounded) until the monitor has seen `target` handshakes; returns 1ns after that edge.
    task automatic wait_hs(input int target, input int budget, input string name);
        int n = 0;
        while (hs_count < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        check(name, (hs_count >= target) ? 32'd1 : 32'd0, 32'd1);
        #1;
    endtask

    task automatic wait_valid(input int budget, input string name);
        int n = 0;
        while (bus.order_valid !== 1'b1 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, {31'd0, bus.order_valid}, 32'd1);
    endtask

    // Scoreboard monitor: a handshake is visible at the negedge before the accepting edge.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && bus.order_valid === 1'b1 && bus.order_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("hs_unexpected", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("buy_price", {24'd0, bus.buy_price}, {24'd0, e.buy});
                check("sell_price", {24'd0, bus.sell_price}, {24'd0, e.sell});
                check("order_id", {24'd0, bus.order_id}, {24'd0, e.id});
                check("match_count_pre", {16'd0, match_count}, {16'd0, e.mc});
                check("mid_range", ((dut.mid_q >= 8'd8) && (dut.mid_q <= 8'd247)) ? 32'd1 : 32'd0, 32'd1);
            end
            hs_cyc.push_back(cyc);
            hs_count++;
        end
    end

    initial begin
        exp_t e;
        int   h0;
        int   h1;
        int   n;

        rst_n = 1'b0; enable = 1'b0; seed_load = 1'b0; seed = 16'h0000;
        interval = 8'd0; bus.order_ready = 1'b0;
        model_reset();

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", {31'd0, bus.order_valid}, 32'd0);
        check("rst_buy", {24'd0, bus.buy_price}, 32'd128);
        check("rst_sell", {24'd0, bus.sell_price}, 32'd128);
        check("rst_id", {24'd0, bus.order_id}, 32'd0);
        check("rst_mc", {16'd0, match_count}, 32'd0);
        check("rst_lfsr", {16'd0, dut.lfsr_state}, 32'h0000ACE1);
        @(posedge clk); #1 rst_n = 1'b1;

        // First order hand-computed; back-to-back every interval+3 = 3 cycles
        gen_order(e);
        e.buy = 8'd126; e.sell = 8'd122; e.id = 8'd0; e.mc = 16'd0;
        exp_q.push_back(e);
        repeat (3) push_order();
        enable = 1'b1; interval = 8'd0; bus.order_ready = 1'b1;
        wait_hs(1, 50, "p1_first_hs_timeout");
        @(negedge clk);
        check("p1_match_count", {16'd0, match_count}, 32'd1);
        wait_hs(4, 50, "p1_hs_timeout");
        bus.order_ready = 1'b0;
        for (int i = 1; i < 4; i++)
            check("p1_gap", hs_cyc[i] - hs_cyc[i-1], 32'd3);

        // Back-pressure: order held for 10 cycles, then exactly one handshake
        push_order();
        wait_valid(10, "p2_valid_timeout");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("p2_hold_valid", {31'd0, bus.order_valid}, 32'd1);
            check("p2_hold_buy", {24'd0, bus.buy_price}, {24'd0, last_e.buy});
            check("p2_hold_sell", {24'd0, bus.sell_price}, {24'd0, last_e.sell});
            check("p2_hold_id", {24'd0, bus.order_id}, {24'd0, last_e.id});
            check("p2_hold_lfsr", {16'd0, dut.lfsr_state}, {16'd0, m_lfsr});
        end
        @(posedge clk); #1 bus.order_ready = 1'b1;
        @(posedge clk); #1 bus.order_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("p2_single_hs", hs_count, 32'd5);

        // Interval 5 -> 8-cycle period; a change during WAIT applies at the next WAIT entry
        h0 = hs_count;
        repeat (4) push_order();
        interval = 8'd5; bus.order_ready = 1'b1;
        wait_hs(h0 + 2, 60, "p3_hs_a_timeout");
        repeat (2) @(posedge clk);
        #1 interval = 8'd1;
        wait_hs(h0 + 4, 60, "p3_hs_b_timeout");
        bus.order_ready = 1'b0;
        check("p3_gap_0", hs_cyc[h0+1] - hs_cyc[h0], 32'd8);
        check("p3_gap_1", hs_cyc[h0+2] - hs_cyc[h0+1], 32'd8);
        check("p3_gap_2", hs_cyc[h0+3] - hs_cyc[h0+2], 32'd4);

        // enable dropped while offering: order stays until accepted, then IDLE
        push_order();
        wait_valid(20, "p4_valid_timeout");
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("p4_kept_valid", {31'd0, bus.order_valid}, 32'd1);
            check("p4_kept_buy", {24'd0, bus.buy_price}, {24'd0, last_e.buy});
        end
        @(posedge clk); #1 bus.order_ready = 1'b1;
        @(posedge clk); #1 bus.order_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("p4_idle_valid", {31'd0, bus.order_valid}, 32'd0);
        end
        check("p4_hs_count", hs_count, h0 + 5);

        // Seed loading in IDLE (non-zero, then zero -> default); ignored in WAIT
        @(posedge clk); #1 seed_load = 1'b1; seed = 16'h1234;
        @(posedge clk); #1 seed_load = 1'b0;
        @(negedge clk);
        check("p4_seed_load", {16'd0, dut.lfsr_state}, 32'h00001234);
        @(posedge clk); #1 seed_load = 1'b1; seed = 16'h0000;
        @(posedge clk); #1 seed_load = 1'b0;
        @(negedge clk);
        check("p4_seed_zero", {16'd0, dut.lfsr_state}, 32'h0000ACE1);
        m_lfsr = 16'hACE1;
        push_order();
        @(posedge clk); #1 enable = 1'b1; interval = 8'd3;
        @(posedge clk); #1 seed_load = 1'b1; seed = 16'h5555;
        @(posedge clk); #1 seed_load = 1'b0;
        @(negedge clk);
        check("p4_seed_ignored_wait", {16'd0, dut.lfsr_state}, 32'h0000ACE1);
        interval = 8'd0; bus.order_ready = 1'b1;
        wait_hs(h0 + 6, 40, "p4_hs_timeout");

        // 1000 orders with random back-pressure: ids wrap, mid stays in range
        h1 = hs_count;
        repeat (1000) push_order();
        n = 0;
        while (hs_count < h1 + 1000 && n < 20000) begin
            @(posedge clk);
            #1 bus.order_ready = ($urandom_range(0, 3) != 0);
            n++;
        end
        bus.order_ready = 1'b0;
        check("p5_hs_done", hs_count, h1 + 1000);
        check("p5_queue_empty", exp_q.size(), 32'd0);

        // Reset while an order is offered: dropped without a handshake
        wait_valid(20, "p6_valid_timeout");
        rst_n = 1'b0; enable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("p6_rst_valid", {31'd0, bus.order_valid}, 32'd0);
        check("p6_rst_id", {24'd0, bus.order_id}, 32'd0);
        check("p6_rst_mc", {16'd0, match_count}, 32'd0);
        check("p6_rst_buy", {24'd0, bus.buy_price}, 32'd128);
        check("p6_rst_hs", hs_count, h1 + 1000);
        @(posedge clk); #1 rst_n = 1'b1;
        model_reset();
        gen_order(e);
        e.buy = 8'd126; e.sell = 8'd122; e.id = 8'd0; e.mc = 16'd0;
        exp_q.push_back(e);
        enable = 1'b1; interval = 8'd0; bus.order_ready = 1'b1;
        wait_hs(h1 + 1001, 50, "p6_hs_timeout");
        bus.order_ready = 1'b0; enable = 1'b0;
        @(negedge clk);
        check("p6_match_count", {16'd0, match_count}, 32'd1);
        repeat (5) @(posedge clk);
        check("final_queue_empty", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
